ray_hit_resolver: RTL and testbench
===================================

Name: ray_hit_resolver

Overview:
- Downstream consumer of the per-object sphere tracer.
- Per pixel, sequences the object list into the tracer one object per cycle and realigns each returned t with its object index and colour.
- Keeps the nearest hit (smallest t) and emits one 12-bit pixel colour per ray with a valid/ready handshake to the frame writer.

Parameters:
- N_OBJ, 4, number of objects in the scene list (>=1).
- IDX_W, 2, object index width; 2**IDX_W >= N_OBJ.
- TRACE_LAT, 3, cycles from obj_addr/object_color presentation to the matching t_in (tracer pipeline depth incl. output register).
- BG_COLOR, 12'h000, colour emitted when no object is hit.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, request to resolve a new ray; sampled only in IDLE.
- busy, output, 1, high in any state except IDLE.
- obj_addr, output, IDX_W, object index driven to the object store / tracer.
- obj_issue, output, 1, high on cycles where obj_addr is a live issue.
- object_color, input, 12, colour of the object at obj_addr, valid the same cycle (combinational store).
- t_in, input, 10, tracer result; 10'h3FF = miss.
- pix_color, output, 12, resolved pixel colour.
- pix_valid, output, 1, pix_color valid.
- pix_ready, input, 1, downstream accepts pix_color.

Behaviour:
- Reset (rst low, async) values: state=IDLE; busy=0; obj_addr=0; obj_issue=0; pix_valid=0; pix_color=BG_COLOR; best_t=10'h3FF; best_color=BG_COLOR; tag pipe all invalid.
- Reset asserted mid-operation aborts the ray; no partial pixel is ever emitted.
- States:
  - IDLE: start=1 -> ISSUE, obj_addr=0, best_t=3FF, best_color=BG_COLOR.
  - ISSUE: obj_issue=1; obj_addr increments each cycle; after index N_OBJ-1 -> DRAIN.
  - DRAIN: wait until last tag retires -> OUT.
  - OUT: pix_valid=1; on pix_valid&&pix_ready -> IDLE.
- start outside IDLE is ignored; no queueing.
- Tag pipe: TRACE_LAT-deep shift register of {valid, last, color[11:0]}, loaded on each issue cycle. The tag emerging at depth TRACE_LAT is aligned with t_in.
- Compare rule, on a valid emerging tag: if t_in != 10'h3FF and t_in < best_t (strict, unsigned), then best_t<=t_in and best_color<=tag.color.
  - Equal t keeps the earlier (lower index) object.
  - t_in=3FF never wins.
- pix_color is registered from the final best_color on the edge the last tag retires (including that tag's own compare); pix_valid rises the same edge.
- Latency: start sampled at edge E0; issue k occurs in cycle E0+1+k; pix_valid is high from cycle E0+N_OBJ+TRACE_LAT+1. Defaults give cycle 8.
- pix_color and pix_valid are held stable while pix_valid=1 and pix_ready=0.
- pix_ready while pix_valid=0 has no effect.
- All issued t_in are consumed exactly once; t_in on cycles with no valid emerging tag is ignored.
- N_OBJ=1: ISSUE lasts one cycle.
- obj_addr wraps to 0 on return to IDLE; it never exceeds N_OBJ-1.

Optional Feature:
- Macro RAY_HIT_DEPTH_EN.
- When defined:
  - Extra outputs hit_t[9:0] and hit_idx[IDX_W-1:0], registered with pix_color and valid under the same handshake.
  - On a miss: hit_t=10'h3FF, hit_idx=0.
  - The tag pipe also carries the index.
- When undefined: the ports and index tag bits are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-ISSUE, then release → busy=0, pix_valid=0, and no pixel is emitted. A following ray resolves correctly.
- Defaults, t per object = {200, 50, 3FF, 120}, colours {F00, 0F0, 00F, FFF} → pix_color=0F0 in cycle 8 after the start edge (hit_t=50, hit_idx=1 with RAY_HIT_DEPTH_EN).
- All t=3FF → pix_color=BG_COLOR, hit_t=3FF.
- Tie: t={80, 80, 300, 3FF}, colours {111, 222, 333, 444} → pix_color=111.
- Backpressure: pix_ready=0 for 5 cycles after pix_valid, plus a start pulse during OUT → output held stable, start ignored. After pix_ready=1 for one cycle → IDLE, then a new start is accepted.
- Back-to-back rays with pix_ready tied 1 → one pixel per N_OBJ+TRACE_LAT+2 cycles, each with the correct colour. obj_issue high exactly N_OBJ cycles per ray.

Source files
------------

// File: rtl/ray_hit_resolver.sv
// ray_hit_resolver
// Sequences the scene's object list into the sphere tracer, one object per
// cycle. Each returned t is realigned with its object's colour, and the
// resolver keeps the nearest hit. It emits one 12-bit pixel per ray with a
// valid/ready handshake.
//
// Build option: define RAY_HIT_DEPTH_EN to add the hit_t_o / hit_idx_o
// outputs. When it is defined, the tag pipe also carries the object index.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_i; the nearest-hit tracker is reset on start
// ISSUE  | presenting object indices 0..N_OBJ-1, one per cycle
// DRAIN  | all objects issued; waiting for the last tag to retire
// OUT    | pixel held on pix_color_o/pix_valid_o until pix_ready_i

module ray_hit_resolver #(
   parameter int          N_OBJ     = 4,
   parameter int          IDX_W     = 2,
   parameter int          TRACE_LAT = 3,
   parameter logic [11:0] BG_COLOR  = 12'h000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   output logic             busy_o,
   output logic [IDX_W-1:0] obj_addr_o,
   output logic             obj_issue_o,
   input  logic [11:0]      object_color_i,
   input  logic [9:0]       t_in_i,
   output logic [11:0]      pix_color_o,
   output logic             pix_valid_o,
   input  logic             pix_ready_i
`ifdef RAY_HIT_DEPTH_EN
   ,
   output logic [9:0]       hit_t_o,
   output logic [IDX_W-1:0] hit_idx_o
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);
   localparam logic [9:0]       T_MISS   = 10'h3FF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] obj_addr_q, obj_addr_d;

   logic             issue;
   logic             last_issue;
   logic             start_acc;

   // Tag pipe: one stage per tracer pipeline cycle. The oldest stage lines up with t_in_i.
   logic [TRACE_LAT-1:0] tag_vld_q;
   logic [TRACE_LAT-1:0] tag_last_q;
   logic [11:0]          tag_color_q [TRACE_LAT];

   logic                 emerge_vld;
   logic                 emerge_last;
   logic [11:0]          emerge_color;
   logic                 hit_win;
   logic                 retire_last;

   logic [9:0]           best_t_q;
   logic [11:0]          best_color_q;
   logic [11:0]          best_color_nxt;
   logic [11:0]          pix_color_q;
   logic                 pix_valid_q;

`ifdef RAY_HIT_DEPTH_EN
   logic [IDX_W-1:0]     tag_idx_q [TRACE_LAT];
   logic [IDX_W-1:0]     emerge_idx;
   logic [IDX_W-1:0]     best_idx_q;
   logic [IDX_W-1:0]     best_idx_nxt;
   logic [9:0]           best_t_nxt;
   logic [9:0]           hit_t_q;
   logic [IDX_W-1:0]     hit_idx_q;
`endif

   assign issue       = (state_q == ST_ISSUE);
   assign last_issue  = issue && (obj_addr_q == LAST_IDX);
   assign start_acc   = (state_q == ST_IDLE) && start_i;

   assign emerge_vld   = tag_vld_q[TRACE_LAT-1];
   assign emerge_last  = tag_last_q[TRACE_LAT-1];
   assign emerge_color = tag_color_q[TRACE_LAT-1];

   // A miss code (3FF) can never win. Ties keep the earlier, lower-index object.
   assign hit_win        = emerge_vld && (t_in_i != T_MISS) && (t_in_i < best_t_q);
   assign retire_last    = emerge_vld && emerge_last;
   assign best_color_nxt = hit_win ? emerge_color : best_color_q;

`ifdef RAY_HIT_DEPTH_EN
   assign emerge_idx   = tag_idx_q[TRACE_LAT-1];
   assign best_idx_nxt = hit_win ? emerge_idx : best_idx_q;
   assign best_t_nxt   = hit_win ? t_in_i : best_t_q;
`endif

   // State and object-address registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         obj_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         obj_addr_q <= obj_addr_d;
      end
   end

   // Next-state logic and address sequencing.
   always_comb begin
      state_d    = state_q;
      obj_addr_d = obj_addr_q;
      unique case (state_q)
         ST_IDLE: begin
            obj_addr_d = '0;
            if (start_i) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (obj_addr_q == LAST_IDX) begin
               state_d    = ST_DRAIN;
               obj_addr_d = '0;
            end else begin
               obj_addr_d = obj_addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (retire_last) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (pix_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            obj_addr_d = '0;
         end
      endcase
   end

   // Tag shift register. Stage 0 captures the object issued this cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_vld_q  <= '0;
         tag_last_q <= '0;
         for (int i = 0; i < TRACE_LAT; i++) begin
            tag_color_q[i] <= '0;
         end
      end else begin
         tag_vld_q[0]   <= issue;
         tag_last_q[0]  <= last_issue;
         tag_color_q[0] <= object_color_i;
         for (int i = 1; i < TRACE_LAT; i++) begin
            tag_vld_q[i]   <= tag_vld_q[i-1];
            tag_last_q[i]  <= tag_last_q[i-1];
            tag_color_q[i] <= tag_color_q[i-1];
         end
      end
   end

`ifdef RAY_HIT_DEPTH_EN
   // Object index travels alongside the colour tag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < TRACE_LAT; i++) begin
            tag_idx_q[i] <= '0;
         end
      end else begin
         tag_idx_q[0] <= obj_addr_q;
         for (int i = 1; i < TRACE_LAT; i++) begin
            tag_idx_q[i] <= tag_idx_q[i-1];
         end
      end
   end
`endif

   // Nearest-hit tracker. It is cleared when a ray is accepted and updated on each winning tag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         best_t_q     <= T_MISS;
         best_color_q <= BG_COLOR;
`ifdef RAY_HIT_DEPTH_EN
         best_idx_q   <= '0;
`endif
      end else if (start_acc) begin
         best_t_q     <= T_MISS;
         best_color_q <= BG_COLOR;
`ifdef RAY_HIT_DEPTH_EN
         best_idx_q   <= '0;
`endif
      end else if (hit_win) begin
         best_t_q     <= t_in_i;
         best_color_q <= emerge_color;
`ifdef RAY_HIT_DEPTH_EN
         best_idx_q   <= emerge_idx;
`endif
      end
   end

   // Pixel output register. It loads as the last tag retires and is held until accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pix_color_q <= BG_COLOR;
         pix_valid_q <= 1'b0;
`ifdef RAY_HIT_DEPTH_EN
         hit_t_q     <= T_MISS;
         hit_idx_q   <= '0;
`endif
      end else if (retire_last) begin
         pix_color_q <= best_color_nxt;
         pix_valid_q <= 1'b1;
`ifdef RAY_HIT_DEPTH_EN
         hit_t_q     <= best_t_nxt;
         hit_idx_q   <= best_idx_nxt;
`endif
      end else if (pix_valid_q && pix_ready_i) begin
         pix_valid_q <= 1'b0;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign obj_issue_o = issue;
   assign obj_addr_o  = obj_addr_q;
   assign pix_color_o = pix_color_q;
   assign pix_valid_o = pix_valid_q;
`ifdef RAY_HIT_DEPTH_EN
   assign hit_t_o     = hit_t_q;
   assign hit_idx_o   = hit_idx_q;
`endif

endmodule

// File: tb/tb_ray_hit_resolver.sv
// Directed bench for ray_hit_resolver. The bench models the tracer as a
// TRACE_LAT delay line. On cycles with no live result, t_in carries a small
// decoy value. That decoy would win if the DUT ever consumed it.

module tb_ray_hit_resolver;

   localparam int          N_OBJ     = 4;
   localparam int          IDX_W     = 2;
   localparam int          TRACE_LAT = 3;
   localparam logic [11:0] BG        = 12'h000;
   localparam int          LAT       = N_OBJ + TRACE_LAT;
   localparam int          PERIOD    = N_OBJ + TRACE_LAT + 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic             busy;
   logic [IDX_W-1:0] obj_addr;
   logic             obj_issue;
   logic [11:0]      object_color;
   logic [9:0]       t_in;
   logic [11:0]      pix_color;
   logic             pix_valid;
   logic             pix_ready = 1'b1;
`ifdef RAY_HIT_DEPTH_EN
   logic [9:0]       hit_t;
   logic [IDX_W-1:0] hit_idx;
`endif

   logic [9:0]           t_tab [N_OBJ];
   logic [11:0]          c_tab [N_OBJ];
   logic [TRACE_LAT-1:0] iss_pipe = '0;
   logic [IDX_W-1:0]     addr_pipe [TRACE_LAT];

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   ray_hit_resolver #(
      .N_OBJ(N_OBJ), .IDX_W(IDX_W), .TRACE_LAT(TRACE_LAT), .BG_COLOR(BG)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .start_i        (start),
      .busy_o         (busy),
      .obj_addr_o     (obj_addr),
      .obj_issue_o    (obj_issue),
      .object_color_i (object_color),
      .t_in_i         (t_in),
      .pix_color_o    (pix_color),
      .pix_valid_o    (pix_valid),
      .pix_ready_i    (pix_ready)
`ifdef RAY_HIT_DEPTH_EN
      ,
      .hit_t_o        (hit_t),
      .hit_idx_o      (hit_idx)
`endif
   );

   always #5 clk = ~clk;

   // Tracer model: the result for an issue appears TRACE_LAT cycles later.
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      iss_pipe    <= {iss_pipe[TRACE_LAT-2:0], obj_issue};
      addr_pipe[0] <= obj_addr;
      for (int i = 1; i < TRACE_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
   end

   assign object_color = c_tab[obj_addr];
   assign t_in = iss_pipe[TRACE_LAT-1] ? t_tab[addr_pipe[TRACE_LAT-1]] : 10'h005;

   task automatic set_scene(input logic [9:0] t0, t1, t2, t3,
                            input logic [11:0] c0, c1, c2, c3);
      t_tab[0] = t0; t_tab[1] = t1; t_tab[2] = t2; t_tab[3] = t3;
      c_tab[0] = c0; c_tab[1] = c1; c_tab[2] = c2; c_tab[3] = c3;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Pulse start, then wait (bounded) for pix_valid. Returns the edges elapsed and the issue cycles seen.
   task automatic start_and_wait(output int lat, output int issues);
      start = 1'b1;
      step();
      start = 1'b0;
      issues = int'(obj_issue);
      lat = 0;
      while (!pix_valid && lat < 40) begin
         step();
         lat++;
         issues += int'(obj_issue);
      end
   endtask

   task automatic run_ray(input string name, input logic [11:0] exp_c,
                          input logic [9:0] exp_t, input logic [IDX_W-1:0] exp_i);
      int lat, issues;
      start_and_wait(lat, issues);
      n_total++;
      if (lat !== LAT) $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
      else n_pass++;
      n_total++;
      if (issues !== N_OBJ) $display("FAIL %s issue_count: got %0d want %0d", name, issues, N_OBJ);
      else n_pass++;
      n_total++;
      if (pix_color !== exp_c) $display("FAIL %s pix_color: got %h want %h", name, pix_color, exp_c);
      else n_pass++;
`ifdef RAY_HIT_DEPTH_EN
      n_total++;
      if (hit_t !== exp_t) $display("FAIL %s hit_t: got %h want %h", name, hit_t, exp_t);
      else n_pass++;
      n_total++;
      if (hit_idx !== exp_i) $display("FAIL %s hit_idx: got %0d want %0d", name, hit_idx, exp_i);
      else n_pass++;
`else
      if (exp_t === 10'h000 && exp_i === '1) $display("note: %s expects t=0 at top index", name);
`endif
      step();
      n_total++;
      if (pix_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL %s handshake_idle: got valid=%b busy=%b want 0/0", name, pix_valid, busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0 || pix_valid !== 1'b0 || obj_issue !== 1'b0 || obj_addr !== '0 || pix_color !== BG)
         $display("FAIL reset_values: got busy=%b valid=%b issue=%b addr=%0d color=%h want 0/0/0/0/%h",
                  busy, pix_valid, obj_issue, obj_addr, pix_color, BG);
      else n_pass++;
`ifdef RAY_HIT_DEPTH_EN
      n_total++;
      if (hit_t !== 10'h3FF || hit_idx !== '0)
         $display("FAIL reset_hit: got t=%h idx=%0d want 3ff/0", hit_t, hit_idx);
      else n_pass++;
`endif
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset_mid_issue();
      bit seen = 1'b0;
      set_scene(10'd200, 10'd50, 10'h3FF, 10'd120, 12'hF00, 12'h0F0, 12'h00F, 12'hFFF);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0 || pix_valid !== 1'b0 || obj_issue !== 1'b0)
         $display("FAIL mid_reset_values: got busy=%b valid=%b issue=%b want 0/0/0", busy, pix_valid, obj_issue);
      else n_pass++;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         seen |= pix_valid | busy;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL mid_reset_no_pixel: got activity=%b want 0", seen);
      else n_pass++;
      run_ray("after_reset", 12'h0F0, 10'd50, 2'd1);
   endtask

   task automatic test_nearest();
      set_scene(10'd200, 10'd50, 10'h3FF, 10'd120, 12'hF00, 12'h0F0, 12'h00F, 12'hFFF);
      run_ray("nearest", 12'h0F0, 10'd50, 2'd1);
      set_scene(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 12'hF00, 12'h0F0, 12'h00F, 12'hFFF);
      run_ray("all_miss", BG, 10'h3FF, 2'd0);
      set_scene(10'h3FF, 10'h3FE, 10'h3FF, 10'h3FF, 12'hABC, 12'hDEF, 12'h123, 12'h456);
      run_ray("max_hit", 12'hDEF, 10'h3FE, 2'd1);
   endtask

   task automatic test_tie();
      set_scene(10'd80, 10'd80, 10'd300, 10'h3FF, 12'h111, 12'h222, 12'h333, 12'h444);
      run_ray("tie", 12'h111, 10'd80, 2'd0);
   endtask

   task automatic test_backpressure();
      int lat, issues;
      logic [11:0] hold;
      set_scene(10'd300, 10'd200, 10'd100, 10'd7, 12'hA01, 12'hA02, 12'hA03, 12'hA04);
      pix_ready = 1'b0;
      start_and_wait(lat, issues);
      n_total++;
      if (lat !== LAT || pix_color !== 12'hA04)
         $display("FAIL bp_first: got lat=%0d color=%h want %0d/a04", lat, pix_color, LAT);
      else n_pass++;
      hold = pix_color;
      for (int k = 0; k < 5; k++) begin
         start = (k == 2);
         step();
         n_total++;
         if (pix_valid !== 1'b1 || pix_color !== hold || obj_issue !== 1'b0)
            $display("FAIL bp_hold%0d: got valid=%b color=%h issue=%b want 1/%h/0",
                     k, pix_valid, pix_color, obj_issue, hold);
         else n_pass++;
      end
      start = 1'b0;
      pix_ready = 1'b1;
      step();
      n_total++;
      if (pix_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL bp_release: got valid=%b busy=%b want 0/0", pix_valid, busy);
      else n_pass++;
      step();
      n_total++;
      if (busy !== 1'b0) $display("FAIL bp_start_ignored: got busy=%b want 0", busy);
      else n_pass++;
      set_scene(10'd80, 10'd80, 10'd300, 10'h3FF, 12'h111, 12'h222, 12'h333, 12'h444);
      run_ray("bp_next", 12'h111, 10'd80, 2'd0);
   endtask

   task automatic test_back_to_back();
      logic [11:0] exp_c [3];
      int last_cyc;
      exp_c[0] = 12'hA04; exp_c[1] = 12'hDEF; exp_c[2] = 12'hC03;
      last_cyc = 0;
      set_scene(10'd300, 10'd200, 10'd100, 10'd7, 12'hA01, 12'hA02, 12'hA03, 12'hA04);
      start = 1'b1;
      for (int r = 0; r < 3; r++) begin
         int n, iss;
         n = 0; iss = 0;
         while (!pix_valid && n < 40) begin
            step();
            n++;
            iss += int'(obj_issue);
         end
         n_total++;
         if (pix_color !== exp_c[r] || iss !== N_OBJ)
            $display("FAIL b2b%0d: got color=%h issues=%0d want %h/%0d", r, pix_color, iss, exp_c[r], N_OBJ);
         else n_pass++;
         if (r > 0) begin
            n_total++;
            if (cyc - last_cyc !== PERIOD)
               $display("FAIL b2b%0d_period: got %0d want %0d", r, cyc - last_cyc, PERIOD);
            else n_pass++;
         end
         last_cyc = cyc;
         if (r == 0) set_scene(10'h3FF, 10'h3FE, 10'h3FF, 10'h3FF, 12'hABC, 12'hDEF, 12'h123, 12'h456);
         else        set_scene(10'h3FE, 10'h3FE, 10'd0, 10'd0, 12'hC01, 12'hC02, 12'hC03, 12'hC04);
         if (r < 2) step();
      end
      start = 1'b0;
      step();
      n_total++;
      if (busy !== 1'b0 || pix_valid !== 1'b0)
         $display("FAIL b2b_end: got busy=%b valid=%b want 0/0", busy, pix_valid);
      else n_pass++;
   endtask

   initial begin
      set_scene(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 12'h0, 12'h0, 12'h0, 12'h0);
      test_reset();
      test_reset_mid_issue();
      test_nearest();
      test_tie();
      test_backpressure();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
